// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment
// display. A shadow register takes processor loads at any time. The display
// register copies the shadow only at frame boundaries, so a frame never shows
// a mix of old and new digits. Each digit slot opens with a blanking gap
// (all anodes off) so that segments from the previous digit do not ghost.
//
// Optional feature:
//   SEVEN_SEG_SCAN_LZB_EN  - leading-zero blanking. When this macro is
//                            defined, high-order zero digits stay dark.
//                            Digit 0 is always shown.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    ld,
    input  logic [4*NUM_DIGITS-1:0] ld_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Counters compare against the parameter bounds. They never rely on
    // power-of-two wrap.
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              boundary;

    logic [DW-1:0]     shadow, shadow_nxt;
    logic [DW-1:0]     disp, disp_nxt;
    logic              pending, pending_nxt;

    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic                    frame_done_nxt;
    logic [3:0]              nib_sel;
    logic                    digit_on;

`ifdef SEVEN_SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic                    sel_supp;
`endif

    // Hex nibble to active-low segment pattern, seg[0]=a .. seg[6]=g.
    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // State, slot counter and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Scan sequencing. A low enable always drops back to IDLE. A frame
    // boundary is either the start from IDLE or the wrap after the last slot.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_BLANK_LAST) begin
                        state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = BLANK;
                        if (idx == IDX_LAST) begin
                            idx_nxt  = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Double buffer. A load on a boundary cycle goes straight to the display
    // so that it is not delayed by a whole frame.
    always_comb begin
        shadow_nxt  = shadow;
        disp_nxt    = disp;
        pending_nxt = pending;
        if (boundary) begin
            if (ld) begin
                disp_nxt   = ld_data;
                shadow_nxt = ld_data;
            end else if (pending) begin
                disp_nxt = shadow;
            end
            pending_nxt = 1'b0;
        end else if (ld) begin
            shadow_nxt  = ld_data;
            pending_nxt = 1'b1;
        end
    end

    // Shadow, display and pending-transfer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            shadow  <= shadow_nxt;
            disp    <= disp_nxt;
            pending <= pending_nxt;
        end
    end

    // Output decode of the state being entered. The registered pins then
    // line up with the state and counters held in the same cycle.
    always_comb begin
        seg_nxt        = 7'h7F;
        an_nxt         = '1;
        frame_done_nxt = 1'b0;
        nib_sel        = 4'h0;
        digit_on       = 1'b0;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        supp     = '0;
        zero_run = 1'b1;
        sel_supp = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_nxt[4*i +: 4] == 4'h0);
            supp[i]  = zero_run && (i != 0);
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nib_sel = disp_nxt[4*i +: 4];
`ifdef SEVEN_SEG_SCAN_LZB_EN
                sel_supp = supp[i];
`endif
            end
        end
        digit_on = (state_nxt == DRIVE);
`ifdef SEVEN_SEG_SCAN_LZB_EN
        digit_on = digit_on && !sel_supp;
`endif
        if (digit_on) begin
            seg_nxt = decode(nib_sel);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_nxt[i] = (idx_nxt != IDX_W'(i));
            end
        end
        frame_done_nxt = (state_nxt == DRIVE) && (idx_nxt == IDX_LAST) &&
                         (cnt_nxt == CNT_LAST);
    end

    // Registered display pins. Reset drives them dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule
